// File: rtl/uart_tx_fifo.sv
// Single-clock 8N1 UART transmitter with baud generator and write FIFO.
// Optional even-parity bit between data and stop: define UART_TX_PARITY_EN.
module uart_tx_fifo #(
  parameter int unsigned CLK_FREQ   = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AW         = 3
) (
  input  logic          sysclk,
  input  logic          reset,
  input  logic [7:0]    TX_DATA,
  input  logic          TX_WE,
  output logic          TX_FULL,
  output logic          TX_EMPTY,
  output logic [AW:0]   TX_COUNT,
  output logic          TX_STATUS,
  output logic          TX_OVF,
  output logic          PC_Uart_txd
);

  localparam int unsigned   DIV     = CLK_FREQ / BAUD;
  localparam int unsigned   CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          push, pop, bit_end, idle_next;
  state_t        state;
  logic [7:0]    shift;
  logic [2:0]    bit_idx;
  logic [CW-1:0] baud_cnt;
`ifdef UART_TX_PARITY_EN
  logic          parity;
`endif

  assign TX_COUNT = count;
  assign TX_FULL  = (count == DEPTH_C);
  assign TX_EMPTY = (count == '0);
  assign bit_end  = (baud_cnt == CNT_MAX);
  assign push     = TX_WE && !TX_FULL;
  // Pop from IDLE, or straight out of STOP so queued frames run back to back.
  assign pop      = !TX_EMPTY && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  always_comb begin
    count_next = count;
    if (push && !pop)
      count_next = count + 1'b1;
    else if (pop && !push)
      count_next = count - 1'b1;
    idle_next = !pop && ((state == S_IDLE) || ((state == S_STOP) && bit_end));
  end

  always_ff @(posedge sysclk) begin
    if (push)
      mem[wr_ptr] <= TX_DATA;
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      TX_OVF <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      if (TX_WE && TX_FULL)
        TX_OVF <= 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      PC_Uart_txd <= 1'b1;
      TX_STATUS   <= 1'b1;
      shift       <= '0;
      bit_idx     <= '0;
      baud_cnt    <= '0;
`ifdef UART_TX_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      TX_STATUS <= idle_next && (count_next == '0);
      if (pop) begin
        shift       <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
        parity      <= ^mem[rd_ptr];
`endif
        baud_cnt    <= '0;
        bit_idx     <= '0;
        PC_Uart_txd <= 1'b0;
        state       <= S_START;
      end else begin
        baud_cnt <= (state == S_IDLE || bit_end) ? '0 : baud_cnt + 1'b1;
        case (state)
          S_IDLE: PC_Uart_txd <= 1'b1;
          S_START: begin
            if (bit_end) begin
              state       <= S_DATA;
              bit_idx     <= '0;
              PC_Uart_txd <= shift[0];
            end
          end
          S_DATA: begin
            if (bit_end) begin
              shift <= shift >> 1;
              if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                state       <= S_PARITY;
                PC_Uart_txd <= parity;
`else
                state       <= S_STOP;
                PC_Uart_txd <= 1'b1;
`endif
              end else begin
                bit_idx     <= bit_idx + 1'b1;
                PC_Uart_txd <= shift[1];
              end
            end
          end
`ifdef UART_TX_PARITY_EN
          S_PARITY: begin
            if (bit_end) begin
              state       <= S_STOP;
              PC_Uart_txd <= 1'b1;
            end
          end
`endif
          S_STOP: begin
            if (bit_end) begin
              state       <= S_IDLE;
              PC_Uart_txd <= 1'b1;
            end
          end
          default: begin
            state       <= S_IDLE;
            PC_Uart_txd <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=16, FIFO_DEPTH=8; outputs sampled on negedge.
// Frame expectations include the parity bit when UART_TX_PARITY_EN is defined.
module tb_uart_tx_fifo;

  localparam int unsigned DIV = 16;

  logic       sysclk = 1'b0;
  logic       reset;
  logic [7:0] TX_DATA;
  logic       TX_WE;
  logic       TX_FULL, TX_EMPTY, TX_STATUS, TX_OVF, PC_Uart_txd;
  logic [3:0] TX_COUNT;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned peak   = 0;

  uart_tx_fifo #(
    .CLK_FREQ  (16),
    .BAUD      (1),
    .FIFO_DEPTH(8),
    .AW        (3)
  ) dut (
    .sysclk     (sysclk),
    .reset      (reset),
    .TX_DATA    (TX_DATA),
    .TX_WE      (TX_WE),
    .TX_FULL    (TX_FULL),
    .TX_EMPTY   (TX_EMPTY),
    .TX_COUNT   (TX_COUNT),
    .TX_STATUS  (TX_STATUS),
    .TX_OVF     (TX_OVF),
    .PC_Uart_txd(PC_Uart_txd)
  );

  always #5 sysclk = ~sysclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of a start-bit's first cycle; returns at the negedge after the stop bit.
  task automatic expect_frame(input logic [7:0] b);
    logic [10:0] bits;
    int unsigned nb;
    int unsigned good;
`ifdef UART_TX_PARITY_EN
    nb   = 11;
    bits = {1'b1, ^b, b, 1'b0};
`else
    nb   = 10;
    bits = {1'b0, 1'b1, b, 1'b0};
`endif
    for (int unsigned k = 0; k < nb; k++) begin
      good = 0;
      for (int unsigned c = 0; c < DIV; c++) begin
        if (PC_Uart_txd === bits[k]) good++;
        if (32'(TX_COUNT) > peak) peak = 32'(TX_COUNT);
        @(negedge sysclk);
      end
      chk($sformatf("frame_%02h_bit%0d", b, k), good, DIV);
    end
  endtask

  task automatic wr(input logic [7:0] b);
    TX_DATA = b;
    TX_WE   = 1'b1;
    @(negedge sysclk);
    TX_WE   = 1'b0;
  endtask

  initial begin
    int unsigned high_cnt;
    reset   = 1'b1;
    TX_WE   = 1'b0;
    TX_DATA = 8'h00;
    repeat (2) @(negedge sysclk);
    chk("rst_txd",    PC_Uart_txd, 1);
    chk("rst_status", TX_STATUS,   1);
    chk("rst_empty",  TX_EMPTY,    1);
    chk("rst_full",   TX_FULL,     0);
    chk("rst_count",  TX_COUNT,    0);
    chk("rst_ovf",    TX_OVF,      0);
    reset = 1'b0;
    @(negedge sysclk);

    // Single byte: entry visible N+1, start bit at N+2, idle again at N+162
    wr(8'hA5);
    TX_DATA = 8'h3C;
    chk("a5_count_n1",  TX_COUNT,  1);
    chk("a5_status_n1", TX_STATUS, 0);
    chk("a5_txd_n1",    PC_Uart_txd, 1);
    @(negedge sysclk);
    chk("a5_count_n2", TX_COUNT, 0);
    expect_frame(8'hA5);
    chk("a5_status_end", TX_STATUS, 1);
    chk("a5_empty_end",  TX_EMPTY,  1);

    // Three consecutive writes: count peaks at 2, frames contiguous
    peak = 0;
    fork
      begin
        TX_DATA = 8'h00; TX_WE = 1'b1;
        @(negedge sysclk); TX_DATA = 8'hFF;
        @(negedge sysclk); TX_DATA = 8'h55;
        @(negedge sysclk); TX_WE = 1'b0; TX_DATA = 8'hEE;
      end
      begin
        repeat (2) @(negedge sysclk);
        expect_frame(8'h00);
        expect_frame(8'hFF);
        expect_frame(8'h55);
      end
    join
    chk("burst3_peak",   peak,      2);
    chk("burst3_status", TX_STATUS, 1);

    // Nine writes fill the FIFO (first popped at once); tenth is dropped and flags overflow
    fork
      begin
        for (int unsigned i = 0; i < 9; i++) begin
          TX_DATA = 8'h10 + 8'(i);
          TX_WE   = 1'b1;
          @(negedge sysclk);
        end
        chk("fill_full",  TX_FULL,  1);
        chk("fill_count", TX_COUNT, 8);
        chk("fill_ovf",   TX_OVF,   0);
        TX_DATA = 8'h19;
        @(negedge sysclk);
        TX_WE   = 1'b0;
        TX_DATA = 8'h00;
        chk("ovf_set",   TX_OVF,   1);
        chk("ovf_count", TX_COUNT, 8);
      end
      begin
        repeat (2) @(negedge sysclk);
        for (int unsigned i = 0; i < 9; i++)
          expect_frame(8'h10 + 8'(i));
      end
    join
    high_cnt = 0;
    for (int unsigned c = 0; c < 2 * DIV; c++) begin
      if (PC_Uart_txd === 1'b1) high_cnt++;
      @(negedge sysclk);
    end
    chk("no_tenth_frame", high_cnt,  2 * DIV);
    chk("fill_status",    TX_STATUS, 1);
    chk("ovf_sticky",     TX_OVF,    1);

    // Reset mid-DATA of 0x3C (bit0 = 0) with another byte queued
    wr(8'h3C);
    wr(8'h99);
    repeat (19) @(negedge sysclk);
    chk("pre_rst_txd",   PC_Uart_txd, 0);
    chk("pre_rst_count", TX_COUNT,    1);
    reset = 1'b1;
    #1;
    chk("async_rst_txd",    PC_Uart_txd, 1);
    chk("async_rst_count",  TX_COUNT,    0);
    chk("async_rst_status", TX_STATUS,   1);
    chk("async_rst_ovf",    TX_OVF,      0);
    @(negedge sysclk);
    reset = 1'b0;
    @(negedge sysclk);
    wr(8'h81);
    @(negedge sysclk);
    expect_frame(8'h81);
    chk("post_rst_status", TX_STATUS, 1);
    chk("post_rst_count",  TX_COUNT,  0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
